// File: rtl/matrix_col_block_split_pkg.sv
// Shared constants and helpers for the 16x64 matrix column-block splitter.
// Optional feature macro: MATRIX_COL_BLOCK_ZERO_IDLE_EN (consumed by the top).
package matrix_pkg;

    localparam int DATA_W  = 16;
    localparam int PE_DIM  = 16;
    localparam int ROWS    = PE_DIM;
    localparam int COLS    = 64;
    localparam int BLK     = PE_DIM;
    localparam int NUM_BLK = COLS / BLK;
    localparam int MAT_W   = ROWS * COLS * DATA_W;
    localparam int BLK_W   = ROWS * BLK * DATA_W;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_VALID = 1'b1
    } split_state_t;

    // Bit offset of element (r, c) in a row-major matrix with ncols columns.
    function automatic int elem_idx(input int r, input int c, input int ncols);
        return (r * ncols + c) * DATA_W;
    endfunction

endpackage

// File: rtl/matrix_col_block_split_if.sv
// Bus between the matrix selector, the splitter and the four PE arrays.
interface matrix_col_block_split_if;

    logic                          en;
    logic [matrix_pkg::MAT_W-1:0]  Matrix;
    logic [matrix_pkg::BLK_W-1:0]  PE16_0;
    logic [matrix_pkg::BLK_W-1:0]  PE16_1;
    logic [matrix_pkg::BLK_W-1:0]  PE16_2;
    logic [matrix_pkg::BLK_W-1:0]  PE16_3;
    logic                          finish;

    modport master (
        output en, Matrix,
        input  PE16_0, PE16_1, PE16_2, PE16_3, finish
    );

    modport slave (
        input  en, Matrix,
        output PE16_0, PE16_1, PE16_2, PE16_3, finish
    );

endinterface

// File: rtl/matrix_col_block_split_col_block_extract.sv
// Combinational extraction of one 16x16 column block starting at START_COL.
// Pure wiring: every element is copied bit-for-bit.
module col_block_extract
    import matrix_pkg::*;
#(
    parameter int START_COL = 0
) (
    input  logic [MAT_W-1:0] matrix,
    output logic [BLK_W-1:0] blk
);

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar j = 0; j < BLK; j++) begin : g_col
            assign blk[elem_idx(r, j, BLK) +: DATA_W] =
                matrix[elem_idx(r, START_COL + j, COLS) +: DATA_W];
        end
    end

endmodule

// File: rtl/matrix_col_block_split.sv
// Registered splitter: 16x64 matrix -> four 16x16 column blocks plus finish.
// PE16_0 carries columns 48..63, PE16_3 carries columns 0..15.
// Optional macro MATRIX_COL_BLOCK_ZERO_IDLE_EN: blocks read 0 while finish=0.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | finish=0, blocks hold last capture
// ST_VALID | finish=1, blocks hold the matrix seen at the last en edge
module matrix_col_block_split
    import matrix_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    matrix_col_block_split_if.slave   bus
);

    split_state_t     state_q;
    split_state_t     state_d;
    logic [BLK_W-1:0] blk_d [NUM_BLK];
    logic [BLK_W-1:0] blk_q [NUM_BLK];
    logic             finish;

    // Index k takes the k-th block counting from the high-column end.
    for (genvar k = 0; k < NUM_BLK; k++) begin : g_blk
        col_block_extract #(
            .START_COL((NUM_BLK - 1 - k) * BLK)
        ) u_extract (
            .matrix (bus.Matrix),
            .blk    (blk_d[k])
        );
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: en alone decides whether the outputs are valid next cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.en)  state_d = ST_VALID;
            ST_VALID: if (!bus.en) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Block registers capture on en and otherwise hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_BLK; k++) blk_q[k] <= '0;
        end else if (bus.en) begin
            for (int k = 0; k < NUM_BLK; k++) blk_q[k] <= blk_d[k];
        end
    end

    assign finish     = (state_q == ST_VALID);
    assign bus.finish = finish;

`ifdef MATRIX_COL_BLOCK_ZERO_IDLE_EN
    assign bus.PE16_0 = finish ? blk_q[0] : '0;
    assign bus.PE16_1 = finish ? blk_q[1] : '0;
    assign bus.PE16_2 = finish ? blk_q[2] : '0;
    assign bus.PE16_3 = finish ? blk_q[3] : '0;
`else
    assign bus.PE16_0 = blk_q[0];
    assign bus.PE16_1 = blk_q[1];
    assign bus.PE16_2 = blk_q[2];
    assign bus.PE16_3 = blk_q[3];
`endif

endmodule

// File: tb/tb_matrix_col_block_split.sv
// Scoreboard bench for matrix_col_block_split: the driver pushes the expected
// post-edge outputs, the monitor pops and compares on each falling edge.
module tb_matrix_col_block_split;
    import matrix_pkg::*;

    localparam int ROW_W = COLS * DATA_W;   // bits per matrix row
    localparam int BROW_W = BLK * DATA_W;   // bits per block row

`ifdef MATRIX_COL_BLOCK_ZERO_IDLE_EN
    localparam bit ZERO_IDLE = 1'b1;
`else
    localparam bit ZERO_IDLE = 1'b0;
`endif

    typedef struct packed {
        logic                        fin;
        logic [3:0][BLK_W-1:0]       pe;
    } exp_t;

    logic clk;
    logic rst;
    matrix_col_block_split_if bus ();

    matrix_col_block_split dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t sb [$];
    int   n_total = 0;
    int   n_pass  = 0;

    // Reference state: what the splitter captured last and whether it is valid.
    logic [3:0][BLK_W-1:0] ref_cap;
    logic                  ref_fin;

    // Block k is the k-th 256-bit slice of each matrix row, counted from the top.
    function automatic logic [BLK_W-1:0] ref_block(input logic [MAT_W-1:0] m, input int k);
        logic [BLK_W-1:0] b;
        logic [ROW_W-1:0] row;
        b = '0;
        for (int r = 0; r < ROWS; r++) begin
            row = m[r*ROW_W +: ROW_W];
            b[r*BROW_W +: BROW_W] = row[(NUM_BLK-1-k)*BROW_W +: BROW_W];
        end
        return b;
    endfunction

    task automatic check_blk(input string name, input logic [BLK_W-1:0] act,
                             input logic [BLK_W-1:0] exp);
        int bad;
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            bad = 0;
            for (int i = BLK_W/DATA_W - 1; i >= 0; i--)
                if (act[i*DATA_W +: DATA_W] !== exp[i*DATA_W +: DATA_W]) bad = i;
            $display("FAIL %s: element %0d got %h want %h", name, bad,
                     act[bad*DATA_W +: DATA_W], exp[bad*DATA_W +: DATA_W]);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    // Drive one cycle of inputs and record the outputs expected after its edge.
    task automatic step(input logic rst_v, input logic en_v, input logic [MAT_W-1:0] m_v);
        exp_t e;
        @(negedge clk);
        #1;
        rst = rst_v;
        bus.en = en_v;
        bus.Matrix = m_v;
        if (!rst_v) begin
            ref_cap = '0;
            ref_fin = 1'b0;
        end else if (en_v) begin
            for (int k = 0; k < NUM_BLK; k++) ref_cap[k] = ref_block(m_v, k);
            ref_fin = 1'b1;
        end else begin
            ref_fin = 1'b0;
        end
        e.fin = ref_fin;
        e.pe  = (ZERO_IDLE && !ref_fin) ? '0 : ref_cap;
        sb.push_back(e);
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        if (rst === 1'b1 && $isunknown(bus.en)) begin
            n_total++;
            $display("FAIL en_x: got %b want 0/1", bus.en);
        end
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check_val("finish", {31'd0, bus.finish}, {31'd0, mon_e.fin});
            check_blk("PE16_0", bus.PE16_0, mon_e.pe[0]);
            check_blk("PE16_1", bus.PE16_1, mon_e.pe[1]);
            check_blk("PE16_2", bus.PE16_2, mon_e.pe[2]);
            check_blk("PE16_3", bus.PE16_3, mon_e.pe[3]);
        end
    end

    function automatic logic [MAT_W-1:0] rand_mat();
        logic [MAT_W-1:0] m;
        for (int i = 0; i < MAT_W/32; i++) m[i*32 +: 32] = $urandom();
        return m;
    endfunction

    logic [MAT_W-1:0] m_ramp;
    logic [MAT_W-1:0] m_ones;
    logic [MAT_W-1:0] m_sign;
    logic [MAT_W-1:0] m_tmp;
    logic [BLK_W-1:0] sign_blk;

    initial begin
        ref_cap = '0;
        ref_fin = 1'b0;
        rst = 1'b0;
        bus.en = 1'b1;
        bus.Matrix = rand_mat();

        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                m_ramp[elem_idx(r, c, COLS) +: DATA_W] = DATA_W'(r*COLS + c);
        m_ones = '1;
        m_sign = '0;
        m_sign[elem_idx(7, 40, COLS) +: DATA_W] = 16'h8000;

        // Reset held with en=1 and nonzero data: reset wins.
        step(1'b0, 1'b1, rand_mat());
        step(1'b0, 1'b1, rand_mat());

        // Ramp matrix, single-cycle en pulse.
        step(1'b1, 1'b1, m_ramp);
        step(1'b1, 1'b0, m_ramp);
        check_val("pe3_0_0",   {16'd0, bus.PE16_3[elem_idx(0, 0, BLK) +: DATA_W]}, 32'd0);
        check_val("pe2_0_0",   {16'd0, bus.PE16_2[elem_idx(0, 0, BLK) +: DATA_W]}, 32'd16);
        check_val("pe1_0_0",   {16'd0, bus.PE16_1[elem_idx(0, 0, BLK) +: DATA_W]}, 32'd32);
        check_val("pe0_0_0",   {16'd0, bus.PE16_0[elem_idx(0, 0, BLK) +: DATA_W]}, 32'd48);
        check_val("pe0_15_15", {16'd0, bus.PE16_0[elem_idx(15, 15, BLK) +: DATA_W]}, 32'd1023);
        check_val("pe3_15_0",  {16'd0, bus.PE16_3[elem_idx(15, 0, BLK) +: DATA_W]}, 32'd960);
        step(1'b1, 1'b0, rand_mat());

        // Tracking with en held high.
        step(1'b1, 1'b1, m_ramp);
        step(1'b1, 1'b1, m_ones);
        step(1'b1, 1'b1, rand_mat());

        // Sign preservation.
        step(1'b1, 1'b1, m_sign);
        step(1'b1, 1'b0, '0);
        sign_blk = '0;
        sign_blk[elem_idx(7, 8, BLK) +: DATA_W] = 16'h8000;
        check_blk("sign_pe1", bus.PE16_1, sign_blk);
        check_blk("sign_pe0", bus.PE16_0, '0);

        // Reset mid-valid clears outputs before the next edge.
        step(1'b1, 1'b1, m_ramp);
        step(1'b0, 1'b1, m_ramp);
        #1;
        check_val("async_fin", {31'd0, bus.finish}, 32'd0);
        check_blk("async_pe0", bus.PE16_0, '0);
        check_blk("async_pe3", bus.PE16_3, '0);

        // Recapture after release.
        step(1'b1, 1'b1, m_ramp);
        step(1'b1, 1'b0, m_ramp);

        // Randomized traffic with occasional reset pulses.
        for (int i = 0; i < 80; i++) begin
            m_tmp = rand_mat();
            step(($urandom_range(0, 15) != 0), 1'($urandom_range(0, 1)), m_tmp);
        end

        step(1'b1, 1'b0, '0);
        repeat (3) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/matrix_col_block_split.md
Name: matrix_col_block_split

Overview:
- Registered splitter for a 16-row x 64-column matrix of signed 16-bit elements.
- Cuts the matrix into four 16x16 column blocks, one per downstream 16x16 PE array.
- Raises `finish` so the PE arrays can start.
- Sits between the 784x64 matrix selector (tail 16-row slice) and the four 16x16 PE instances.

Parameters:
- DATA_W, 16: element width in bits (signed two's complement).
- ROWS, 16: matrix rows.
- COLS, 64: matrix columns.
- BLK, 16: columns per output block. NUM_BLK = COLS/BLK = 4 (derived, not overridable).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset (0 = reset).
- en  in  1  capture request.
- Matrix  in  ROWS*COLS*DATA_W (16384)  input matrix, row-major; element (r,c) at bits [(r*COLS+c)*DATA_W +: DATA_W].
- PE16_0  out  ROWS*BLK*DATA_W (4096)  block of columns 48..63.
- PE16_1  out  4096  block of columns 32..47.
- PE16_2  out  4096  block of columns 16..31.
- PE16_3  out  4096  block of columns 0..15.
- finish  out  1  block outputs valid.

Behaviour:
- Block layout: row-major. Block element (r,j) sits at [(r*BLK+j)*DATA_W +: DATA_W]. For PE16_k, (r,j) equals Matrix element (r, (NUM_BLK-1-k)*BLK + j).
- Block ordering is fixed so that {PE16_0, PE16_1, PE16_2, PE16_3} concatenated back equals Matrix column order MSB-first.
- Pure bit selection: no arithmetic, no sign extension, no truncation.
- Reset (rst=0, asynchronous, any time): PE16_0..3 = 0 and finish = 0 immediately, held while rst=0.
- Capture: on each rising clk with rst=1 and en=1, all four blocks register from the current Matrix and finish <= 1.
- Latency is 1 cycle from en sampled high to valid outputs and finish=1.
- Matrix changing while en stays high: outputs track it with 1-cycle latency, and finish stays 1.
- Idle: on a rising clk with en=0, finish <= 0 and block outputs hold their last captured value.
- Only the two states above exist (IDLE: finish=0; VALID: finish=1); VALID is entered and held by en=1, left by en=0 or reset.
- Reset asserted mid-operation: outputs clear asynchronously. After release, the first edge with en=1 recaptures normally.
- Simultaneous rst=0 and en=1: reset wins.
- X on en is not permitted after reset release. The bench treats it as an error.

Optional Feature:
- Macro MATRIX_COL_BLOCK_ZERO_IDLE_EN.
- When defined: PE16_0..3 are combinationally forced to 0 whenever finish=0, so data is visible only while valid.
- When undefined (default): outputs hold the last captured values while finish=0, as described in Behaviour.
- finish timing is identical in both builds.

Decomposition:
- Shared package matrix_pkg holds:
  - DATA_W, PE dimension 16, COLS 64.
  - A localparam for block width in bits (4096).
  - A function `elem_idx(r, c, ncols)` returning the element's bit offset.
- One sub-module, col_block_extract, parameterised by block-start column. It is combinational, maps Matrix to one 4096-bit block, and is instantiated 4 times. The top level holds the output registers, finish and the macro gating.

Test Plan:
- Reset: hold rst=0 with en=1 and nonzero Matrix -> all PE16_x = 0 and finish = 0. Asserting rst=0 mid-valid clears outputs before the next clk edge.
- Basic split: Matrix element (r,c) = r*64+c, pulse en for one cycle -> 1 cycle later finish=1 and:
  - PE16_3(0,0) = 0.
  - PE16_2(0,0) = 16.
  - PE16_1(0,0) = 32.
  - PE16_0(0,0) = 48.
  - PE16_0(15,15) = 1023.
  - PE16_3(15,0) = 960.
- Next cycle after that pulse, with en=0 -> finish=0 and blocks unchanged. Under MATRIX_COL_BLOCK_ZERO_IDLE_EN, blocks read 0 instead.
- Tracking: en held high and Matrix changed to all -1 (16'hFFFF) -> next cycle all blocks all-ones and finish stays 1.
- Sign preservation: element (7,40) = 16'h8000, others 0 -> PE16_1(7,8) = 16'h8000 and every other bit of every block is 0.
- Recapture after reset: rst pulse low then high, en=1 -> finish=1 exactly one edge later with correct blocks.
